// File: rtl/src_injection_arbiter.sv
// ---------------------------------------------------------------------------
// src_injection_arbiter
//
// Lets NUM_REQ traffic sources share one NoC router injection port.
// Each cycle at most one source gets a one-cycle grant on ready_out.
// Sources are picked round-robin, and a source whose done_in bit is set
// is skipped. A granted source presents its beat in the following cycle.
// That beat is written into a small first-word-fall-through FIFO, and the
// FIFO drains to the router with a valid/ready handshake.
//
// Ports
//   clk        clock
//   rst        synchronous reset, active high
//   done_in    per-source done; a set bit removes that source from the search
//   data_in    packed source data, source i at [i*WIDTH +: WIDTH]
//   dest_in    packed source destination router addresses
//   vc_in      packed source virtual-channel indices
//   valid_in   per-source beat valid, meaningful only the cycle after a grant
//   ready_out  one-hot grant: "present your beat next cycle"
//   data_out   FIFO head data
//   dest_out   FIFO head destination
//   vc_out     FIFO head VC
//   valid_out  FIFO holds at least one beat
//   ready_in   router accepts the head beat this cycle
//   all_done   every source done, FIFO empty and no grant outstanding
//   proto_err  sticky flag: a granted source failed to present a beat
// ---------------------------------------------------------------------------
module src_injection_arbiter #(
   parameter int WIDTH         = 32,
   parameter int N             = 16,
   parameter int NUM_VC        = 2,
   parameter int N_ADDR_WIDTH  = $clog2(N),
   parameter int VC_ADDR_WIDTH = $clog2(NUM_VC),
   parameter int NUM_REQ       = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               done_in,
   input  logic [NUM_REQ*WIDTH-1:0]         data_in,
   input  logic [NUM_REQ*N_ADDR_WIDTH-1:0]  dest_in,
   input  logic [NUM_REQ*VC_ADDR_WIDTH-1:0] vc_in,
   input  logic [NUM_REQ-1:0]               valid_in,
   output logic [NUM_REQ-1:0]               ready_out,
   output logic [WIDTH-1:0]                 data_out,
   output logic [N_ADDR_WIDTH-1:0]          dest_out,
   output logic [VC_ADDR_WIDTH-1:0]         vc_out,
   output logic                             valid_out,
   input  logic                             ready_in,
   output logic                             all_done,
   output logic                             proto_err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = WIDTH + N_ADDR_WIDTH + VC_ADDR_WIDTH;

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pend_src;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_found;
   logic             grant;
   logic             pend;
   logic             space;
   logic [CNT_W:0]   occupancy;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] beat;

   // A grant goes out on ready_out, so any bit still set there means a beat
   // is due this cycle from pend_src.
   assign pend = |ready_out;

   // Reserve a FIFO slot for the beat that is already in flight. Pops in
   // the current cycle are not counted, so a full FIFO can never overflow.
   always_comb begin
      occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pend};
      space     = occupancy < (CNT_W+1)'(FIFO_DEPTH);
   end

   // Round-robin search starting one past the last winner. The loop runs
   // from the farthest offset down to the nearest one. Each eligible
   // candidate overwrites the previous result, so the closest eligible
   // source is the one left at the end.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         logic [IDX_W-1:0] cand;
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!done_in[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
      grant = grant_found && space;
   end

   // The beat of the granted source is taken from its slice of the inputs.
   // Valid bits of all other sources are ignored.
   always_comb begin
      beat = {data_in[pend_src*WIDTH +: WIDTH],
              dest_in[pend_src*N_ADDR_WIDTH +: N_ADDR_WIDTH],
              vc_in[pend_src*VC_ADDR_WIDTH +: VC_ADDR_WIDTH]};
      push = pend && valid_in[pend_src];
      pop  = (count != '0) && ready_in;
   end

   // The head is read straight out of the storage array (first-word fall
   // through). It stays put while ready_in is low.
   always_comb begin
      {data_out, dest_out, vc_out} = mem[rd_ptr];
      valid_out = (count != '0);
      all_done  = (&done_in) && (count == '0) && !pend;
   end

   // Grant register, round-robin pointer and protocol-error flag.
   // The pointer resets to the last source so that source 0 wins first.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_out <= '0;
         pend_src  <= '0;
         rr_ptr    <= IDX_W'(NUM_REQ - 1);
         proto_err <= 1'b0;
      end else begin
         ready_out <= '0;
         if (grant) begin
            ready_out[grant_idx] <= 1'b1;
            pend_src             <= grant_idx;
            rr_ptr               <= grant_idx;
         end
         if (pend && !valid_in[pend_src]) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Output FIFO. A push and a pop in the same cycle leave count unchanged.
   // The pointers wrap on their own because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= beat;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: tb/tb_src_injection_arbiter.sv
// ---------------------------------------------------------------------------
// tb_src_injection_arbiter
//
// Drives the arbiter with sources that follow the grant protocol. Each
// source sends a running per-source counter as its data, and the other
// inputs are random. A queue-based reference model predicts the outputs
// every cycle: grant, FIFO head, valid, all_done and proto_err.
// ---------------------------------------------------------------------------
module tb_src_injection_arbiter;

   localparam int WIDTH   = 32;
   localparam int NA      = 4;
   localparam int VA      = 1;
   localparam int NUM_REQ = 4;
   localparam int DEPTH   = 4;
   localparam int ENT_W   = WIDTH + NA + VA;

   logic                     clk;
   logic                     rst;
   logic [NUM_REQ-1:0]       done_in;
   logic [NUM_REQ*WIDTH-1:0] data_in;
   logic [NUM_REQ*NA-1:0]    dest_in;
   logic [NUM_REQ*VA-1:0]    vc_in;
   logic [NUM_REQ-1:0]       valid_in;
   logic [NUM_REQ-1:0]       ready_out;
   logic [WIDTH-1:0]         data_out;
   logic [NA-1:0]            dest_out;
   logic [VA-1:0]            vc_out;
   logic                     valid_out;
   logic                     ready_in;
   logic                     all_done;
   logic                     proto_err;

   src_injection_arbiter #(
      .WIDTH(WIDTH), .N(16), .NUM_VC(2), .NUM_REQ(NUM_REQ), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .done_in(done_in), .data_in(data_in),
      .dest_in(dest_in), .vc_in(vc_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .dest_out(dest_out),
      .vc_out(vc_out), .valid_out(valid_out), .ready_in(ready_in),
      .all_done(all_done), .proto_err(proto_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   int               model_ptr;
   int               model_pend;
   bit               model_proto;
   logic [ENT_W-1:0] model_q[$];
   int               data_counter[NUM_REQ];
   bit               drop_src2;
   bit               beat_sent;
   logic [ENT_W-1:0] beat_sent_ent;
   int               max_occ;

   int total;
   int bad;

   // One comparison: count it, and count and report it if it fails
   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      model_ptr   = NUM_REQ - 1;
      model_pend  = -1;
      model_proto = 1'b0;
      model_q.delete();
   endtask

   // Drive one cycle of inputs just after the clock edge. The source that
   // holds an outstanding grant presents its next counter value, unless a
   // dropped beat has been requested for source 2.
   task automatic apply_stimulus(input logic [NUM_REQ-1:0] done, input bit rdy);
      done_in   = done;
      ready_in  = rdy;
      beat_sent = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid_in[i]             = 1'($urandom_range(0, 1));
         data_in[i*WIDTH +: WIDTH] = $urandom;
         dest_in[i*NA +: NA]     = NA'($urandom);
         vc_in[i*VA +: VA]       = VA'($urandom);
      end
      if (model_pend >= 0) begin
         if (drop_src2 && model_pend == 2) begin
            valid_in[model_pend] = 1'b0;
            drop_src2 = 1'b0;
         end else begin
            valid_in[model_pend] = 1'b1;
            data_in[model_pend*WIDTH +: WIDTH] = {8'(model_pend), 24'(data_counter[model_pend])};
            data_counter[model_pend]++;
            beat_sent     = 1'b1;
            beat_sent_ent = {data_in[model_pend*WIDTH +: WIDTH],
                             dest_in[model_pend*NA +: NA],
                             vc_in[model_pend*VA +: VA]};
         end
      end
   endtask

   // Compare every output against the model state for the current cycle
   task automatic compare_cycle();
      logic [NUM_REQ-1:0] exp_ready;
      exp_ready = '0;
      if (model_pend >= 0) exp_ready[model_pend] = 1'b1;
      check_output("ready_out", 64'(ready_out), 64'(exp_ready));
      check_output("valid_out", 64'(valid_out), 64'(model_q.size() != 0));
      if (model_q.size() != 0)
         check_output("head", 64'({data_out, dest_out, vc_out}), 64'(model_q[0]));
      check_output("all_done", 64'(all_done),
                   64'((&done_in) && model_q.size() == 0 && model_pend < 0));
      check_output("proto_err", 64'(proto_err), 64'(model_proto));
   endtask

   // Advance the model by one clock, based on the rules of the protocol
   task automatic update_model();
      int  cnt;
      int  pnd;
      int  winner;
      bit  pop;
      cnt = model_q.size();
      pnd = (model_pend >= 0) ? 1 : 0;
      pop = (cnt > 0) && ready_in;
      if (pnd == 1 && !beat_sent) model_proto = 1'b1;
      winner = -1;
      if (cnt + pnd < DEPTH) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            if (!done_in[(model_ptr + k) % NUM_REQ]) begin
               winner = (model_ptr + k) % NUM_REQ;
               break;
            end
         end
      end
      if (pop) void'(model_q.pop_front());
      if (beat_sent) model_q.push_back(beat_sent_ent);
      if (model_q.size() > max_occ) max_occ = model_q.size();
      if (winner >= 0) model_ptr = winner;
      model_pend = winner;
   endtask

   task automatic run_cycle(input logic [NUM_REQ-1:0] done, input bit rdy);
      apply_stimulus(done, rdy);
      @(negedge clk);
      compare_cycle();
      update_model();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_output("rst_ready_out", 64'(ready_out), 64'(0));
      check_output("rst_valid_out", 64'(valid_out), 64'(0));
      check_output("rst_data_out", 64'({data_out, dest_out, vc_out}), 64'(0));
      check_output("rst_proto_err", 64'(proto_err), 64'(0));
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      max_occ   = 0;
      drop_src2 = 1'b0;
      beat_sent = 1'b0;
      beat_sent_ent = '0;
      for (int i = 0; i < NUM_REQ; i++) data_counter[i] = 0;
      rst      = 1'b1;
      done_in  = '0;
      data_in  = '0;
      dest_in  = '0;
      vc_in    = '0;
      valid_in = '0;
      ready_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // All sources active, router always ready
      $display("[TB] step 1: round robin, sustained");
      for (int c = 0; c < 12; c++) run_cycle(4'b0000, 1'b1);

      // Router stalls: four grants fill the FIFO, then it drains in order
      $display("[TB] step 2: backpressure then drain");
      for (int c = 0; c < 8; c++) run_cycle(4'b0000, 1'b0);
      for (int c = 0; c < 8; c++) run_cycle(4'b0000, 1'b1);

      // Only sources 1 and 3 eligible, then everyone done
      $display("[TB] step 3: done masking and all_done");
      for (int c = 0; c < 8; c++) run_cycle(4'b0101, 1'b1);
      for (int c = 0; c < 6; c++) run_cycle(4'b1111, 1'b1);
      check_output("all_done_final", 64'(all_done), 64'(1));

      // Source 2 withholds its beat after a grant
      $display("[TB] step 4: protocol error");
      drop_src2 = 1'b1;
      for (int c = 0; c < 16 && !model_proto; c++) run_cycle(4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) run_cycle(4'b0000, 1'b1);
      check_output("proto_err_sticky", 64'(proto_err), 64'(1));

      // Reset with three beats stored and one grant in flight
      $display("[TB] step 5: reset mid-traffic");
      for (int c = 0; c < 20 && !(model_q.size() == 3 && model_pend >= 0); c++)
         run_cycle(4'b0000, 1'b0);
      check_output("pre_reset_state", 64'({valid_out, |ready_out}), 64'(2'b11));
      do_reset();
      for (int c = 0; c < 4; c++) run_cycle(4'b0000, 1'b1);

      // Random router readiness and done masks against the scoreboard
      $display("[TB] step 6: randomized traffic");
      for (int c = 0; c < 300; c++) begin
         logic [NUM_REQ-1:0] d;
         d = ($urandom_range(0, 3) == 0) ? NUM_REQ'($urandom) : '0;
         run_cycle(d, 1'($urandom_range(0, 3) != 0));
      end
      for (int c = 0; c < 40; c++) run_cycle(4'b0000, 1'($urandom_range(0, 1)));
      for (int c = 0; c < 10; c++) run_cycle(4'b1111, 1'b1);
      check_output("all_done_end", 64'(all_done), 64'(1));
      $display("[TB] peak model occupancy %0d", max_occ);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
